// File: rtl/rv32_mem_arbiter.sv
// rtl/rv32_mem_arbiter.sv - fetch/load-store arbiter sharing one memory port
// Data wins ties; a starvation counter forces a fetch grant after STARVE_LIMIT losses.
module rv32_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_read_in,
  input  logic [31:0] instr_address_in,
  output logic        instr_ready_out,
  output logic [31:0] instr_read_value_out,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [31:0] data_address_in,
  input  logic [31:0] data_write_value_in,
  input  logic [3:0]  data_write_mask_in,
  output logic        data_ready_out,
  output logic [31:0] data_read_value_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [31:0] mem_address_out,
  output logic [31:0] mem_write_value_out,
  output logic [3:0]  mem_write_mask_out,
  input  logic        mem_ready_in,
  input  logic [31:0] mem_read_value_in
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INSTR = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

  logic [1:0]  r_state;
  logic [3:0]  r_starve;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wval;
  logic [3:0]  r_mem_mask;
  logic        r_instr_ready;
  logic        r_data_ready;
  logic [31:0] r_instr_val;
  logic [31:0] r_data_val;

  logic w_pend_i;
  logic w_pend_d;
  logic w_grant_i;

  assign w_pend_i  = instr_read_in;
  assign w_pend_d  = data_read_in | data_write_in;
  assign w_grant_i = w_pend_i & (~w_pend_d | (r_starve == LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_starve      <= 4'd0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= 32'd0;
      r_mem_wval    <= 32'd0;
      r_mem_mask    <= 4'd0;
      r_instr_ready <= 1'b0;
      r_data_ready  <= 1'b0;
      r_instr_val   <= 32'd0;
      r_data_val    <= 32'd0;
    end else begin
      r_instr_ready <= 1'b0;
      r_data_ready  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_i) begin
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= instr_address_in;
            r_mem_mask  <= 4'd0;
            r_starve    <= 4'd0;
            r_state     <= S_INSTR;
          end else if (w_pend_d) begin
            // A simultaneous read+write request is served as a store only.
            r_mem_read  <= ~data_write_in;
            r_mem_write <= data_write_in;
            r_mem_addr  <= data_address_in;
            r_mem_wval  <= data_write_value_in;
            r_mem_mask  <= data_write_mask_in;
            if (w_pend_i) r_starve <= r_starve + 4'd1;
            r_state     <= S_DATA;
          end
        end
        S_INSTR: begin
          if (mem_ready_in) begin
            r_instr_val   <= mem_read_value_in;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_instr_ready <= 1'b1;
            r_state       <= S_RESP;
          end
        end
        S_DATA: begin
          if (mem_ready_in) begin
            r_data_val   <= r_mem_write ? 32'd0 : mem_read_value_in;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_data_ready <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready_out      = r_instr_ready;
  assign instr_read_value_out = r_instr_val;
  assign data_ready_out       = r_data_ready;
  assign data_read_value_out  = r_data_val;
  assign mem_read_out         = r_mem_read;
  assign mem_write_out        = r_mem_write;
  assign mem_address_out      = r_mem_addr;
  assign mem_write_value_out  = r_mem_wval;
  assign mem_write_mask_out   = r_mem_mask;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb/tb_rv32_mem_arbiter.sv - directed self-checking bench for rv32_mem_arbiter
module tb_rv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_read_in;
  logic [31:0] instr_address_in;
  logic        instr_ready_out;
  logic [31:0] instr_read_value_out;
  logic        data_read_in;
  logic        data_write_in;
  logic [31:0] data_address_in;
  logic [31:0] data_write_value_in;
  logic [3:0]  data_write_mask_in;
  logic        data_ready_out;
  logic [31:0] data_read_value_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [31:0] mem_address_out;
  logic [31:0] mem_write_value_out;
  logic [3:0]  mem_write_mask_out;
  logic        mem_ready_in;
  logic [31:0] mem_read_value_in;

  int total = 0;
  int bad   = 0;

  rv32_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .instr_read_in(instr_read_in), .instr_address_in(instr_address_in),
    .instr_ready_out(instr_ready_out), .instr_read_value_out(instr_read_value_out),
    .data_read_in(data_read_in), .data_write_in(data_write_in),
    .data_address_in(data_address_in), .data_write_value_in(data_write_value_in),
    .data_write_mask_in(data_write_mask_in), .data_ready_out(data_ready_out),
    .data_read_value_out(data_read_value_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .mem_address_out(mem_address_out),
    .mem_write_value_out(mem_write_value_out), .mem_write_mask_out(mem_write_mask_out),
    .mem_ready_in(mem_ready_in), .mem_read_value_in(mem_read_value_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_read_in = 0; instr_address_in = 0;
    data_read_in = 0; data_write_in = 0; data_address_in = 0;
    data_write_value_in = 0; data_write_mask_in = 0;
    mem_ready_in = 0; mem_read_value_in = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  initial begin
    string seq;
    string exp_seq;
    int    n;
    idle_inputs();
    do_reset();

    // reset state
    chk("rst_mem_read", mem_read_out, 0);
    chk("rst_mem_write", mem_write_out, 0);
    chk("rst_addr", mem_address_out, 0);
    chk("rst_mask", mem_write_mask_out, 0);
    chk("rst_iready", instr_ready_out, 0);
    chk("rst_dready", data_ready_out, 0);
    chk("rst_starve", dut.r_starve, 0);

    // single fetch
    instr_read_in = 1; instr_address_in = 32'h40;
    tick();
    chk("fetch_strobe", mem_read_out, 1);
    chk("fetch_addr", mem_address_out, 32'h40);
    chk("fetch_nowrite", mem_write_out, 0);
    chk("fetch_mask", mem_write_mask_out, 0);
    tick();
    chk("fetch_wait_iready", instr_ready_out, 0);
    mem_ready_in = 1; mem_read_value_in = 32'hDEAD_BEEF;
    tick();
    chk("fetch_iready", instr_ready_out, 1);
    chk("fetch_value", instr_read_value_out, 32'hDEAD_BEEF);
    chk("fetch_no_dready", data_ready_out, 0);
    chk("fetch_strobe_drop", mem_read_out, 0);
    instr_read_in = 0; mem_ready_in = 0;
    tick();
    chk("fetch_pulse_end", instr_ready_out, 0);

    // byte store
    data_write_in = 1; data_address_in = 32'h103;
    data_write_value_in = 32'hAB; data_write_mask_in = 4'b0001;
    tick();
    chk("st_write", mem_write_out, 1);
    chk("st_read", mem_read_out, 0);
    chk("st_mask", mem_write_mask_out, 4'b0001);
    chk("st_wval", mem_write_value_out, 32'hAB);
    chk("st_addr", mem_address_out, 32'h103);
    mem_ready_in = 1; mem_read_value_in = 32'h1234_5678;
    tick();
    chk("st_dready", data_ready_out, 1);
    chk("st_rvalue", data_read_value_out, 0);
    idle_inputs();
    tick();
    chk("st_pulse_end", data_ready_out, 0);

    // wait states on a load
    data_read_in = 1; data_address_in = 32'h200;
    tick();
    chk("ws_strobe", mem_read_out, 1);
    chk("ws_addr", mem_address_out, 32'h200);
    data_address_in = 32'h300;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ws_hold_read", mem_read_out, 1);
      chk("ws_hold_addr", mem_address_out, 32'h200);
      chk("ws_no_ready", data_ready_out, 0);
    end
    mem_ready_in = 1; mem_read_value_in = 32'hCAFE_F00D;
    tick();
    chk("ws_dready", data_ready_out, 1);
    chk("ws_value", data_read_value_out, 32'hCAFE_F00D);
    idle_inputs();
    tick();
    chk("ws_single_pulse", data_ready_out, 0);

    // reset mid-access
    data_read_in = 1; data_address_in = 32'h400;
    tick();
    chk("rm_strobe", mem_read_out, 1);
    reset = 1; data_read_in = 0;
    tick();
    chk("rm_read", mem_read_out, 0);
    chk("rm_write", mem_write_out, 0);
    chk("rm_addr", mem_address_out, 0);
    chk("rm_dready", data_ready_out, 0);
    chk("rm_dvalue", data_read_value_out, 0);
    reset = 0; mem_ready_in = 1; mem_read_value_in = 32'h5555_5555;
    tick();
    chk("rm_late_ready1", data_ready_out, 0);
    tick();
    chk("rm_late_ready2", data_ready_out, 0);
    chk("rm_late_strobe", mem_read_out, 0);
    instr_read_in = 1; instr_address_in = 32'h80; mem_read_value_in = 32'h0BAD_F00D;
    tick();
    chk("rm_next_strobe", mem_read_out, 1);
    chk("rm_next_addr", mem_address_out, 32'h80);
    tick();
    chk("rm_next_iready", instr_ready_out, 1);
    chk("rm_next_value", instr_read_value_out, 32'h0BAD_F00D);
    idle_inputs();
    tick();

    // read and write both high
    data_read_in = 1; data_write_in = 1; data_address_in = 32'h500;
    data_write_value_in = 32'h1122_3344; data_write_mask_in = 4'hF;
    tick();
    chk("rw_write", mem_write_out, 1);
    chk("rw_read", mem_read_out, 0);
    chk("rw_wval", mem_write_value_out, 32'h1122_3344);
    mem_ready_in = 1; mem_read_value_in = 32'hFFFF_FFFF;
    tick();
    chk("rw_dready", data_ready_out, 1);
    chk("rw_value", data_read_value_out, 0);
    idle_inputs();
    tick();

    // tie and starvation with a zero-wait memory
    do_reset();
    instr_read_in = 1; instr_address_in = 32'h1000;
    data_read_in = 1; data_address_in = 32'h2000;
    mem_ready_in = 1; mem_read_value_in = 32'h7777_0000;
    seq = "";
    exp_seq = "DDDDIDDDD";
    n = 0;
    for (int c = 0; c < 60 && n < 9; c++) begin
      tick();
      if (instr_ready_out) begin
        seq = {seq, "I"};
        n++;
        chk("tie_starve_clear", dut.r_starve, 0);
      end else if (data_ready_out) begin
        seq = {seq, "D"};
        n++;
      end
    end
    chk("tie_count", n, 9);
    for (int k = 0; k < 9; k++) begin
      if (k < seq.len()) chk($sformatf("tie_grant%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
    end
    idle_inputs();
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
